// File: rtl/keypad_pkg.sv
// keypad_pkg: shared definitions for the matrix-keypad controller.
//   - scan_state_e: scan FSM states
//   - register offsets within the MMIO block, STATUS/DATA/CTRL bit positions
//   - lowest_zero(): column priority encoder (lowest active-low column wins)
//   - key_code():    (row index, column index) -> 4-bit key code
package keypad_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    SCAN     = 2'd2,
    RELEASE  = 2'd3
  } scan_state_e;

  localparam logic [2:0] REG_DATA   = 3'b000;
  localparam logic [2:0] REG_STATUS = 3'b010;
  localparam logic [2:0] REG_CTRL   = 3'b100;

  localparam int DATA_VALID     = 15;
  localparam int STAT_NONEMPTY  = 0;
  localparam int STAT_IRQ_EN    = 1;
  localparam int STAT_OVERFLOW  = 2;
  localparam int STAT_COUNT_LSB = 3;
  localparam int CTRL_IRQ_EN    = 0;
  localparam int CTRL_FLUSH     = 1;

  function automatic logic [1:0] lowest_zero(input logic [3:0] col);
    if (!col[0])      return 2'd0;
    else if (!col[1]) return 2'd1;
    else if (!col[2]) return 2'd2;
    else              return 2'd3;
  endfunction

  // Row 3 is the bottom row: '*' maps to E and '#' maps to F.
  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    case ({r, c})
      4'd0:    return 4'h1;
      4'd1:    return 4'h2;
      4'd2:    return 4'h3;
      4'd3:    return 4'hA;
      4'd4:    return 4'h4;
      4'd5:    return 4'h5;
      4'd6:    return 4'h6;
      4'd7:    return 4'hB;
      4'd8:    return 4'h7;
      4'd9:    return 4'h8;
      4'd10:   return 4'h9;
      4'd11:   return 4'hC;
      4'd12:   return 4'hE;
      4'd13:   return 4'h0;
      4'd14:   return 4'hF;
      default: return 4'hD;
    endcase
  endfunction

endpackage

// File: rtl/keypad_ctrl_if.sv
// keypad_ctrl_if: CPU-side MMIO bus of the keypad controller.
//   read_enable/write_enable : one-cycle access strobes
//   address                  : register select within the block
//   write_data               : CPU write data
//   read_data_output         : combinational register read data
//   interrupt                : level interrupt to the CPU
// master = CPU side, slave = peripheral side.
interface keypad_ctrl_if;
  logic        read_enable;
  logic        write_enable;
  logic [2:0]  address;
  logic [15:0] write_data;
  logic [15:0] read_data_output;
  logic        interrupt;

  modport master (
    output read_enable, write_enable, address, write_data,
    input  read_data_output, interrupt
  );

  modport slave (
    input  read_enable, write_enable, address, write_data,
    output read_data_output, interrupt
  );
endinterface

// File: rtl/key_fifo.sv
// key_fifo: small key-code queue (4-bit entries, DEPTH a power of two, 2..16).
//   push/push_data : enqueue; dropped and overflow set when full (unless popping)
//   pop            : dequeue; ignored when empty
//   flush          : empties the queue, overrides push and pop
//   clear_overflow : clears the sticky overflow flag (a new overflow wins)
//   head           : current head entry (valid only when !empty)
//   full/empty/count/overflow : status
// State updates on the falling clock edge like the other MMIO peripherals.
module key_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       push,
  input  logic [3:0] push_data,
  input  logic       pop,
  input  logic       flush,
  input  logic       clear_overflow,
  output logic [3:0] head,
  output logic       full,
  output logic       empty,
  output logic [4:0] count,
  output logic       overflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [3:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign do_pop  = pop & ~empty & ~flush;
  assign do_push = push & (~full | do_pop) & ~flush;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(negedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count_q  <= '0;
      overflow <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        count_q <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + 1'b1;
        if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({do_push, do_pop})
          2'b10:   count_q <= count_q + 1'b1;
          2'b01:   count_q <= count_q - 1'b1;
          default: ;
        endcase
      end
      if (push && full && !do_pop && !flush) overflow <= 1'b1;
      else if (clear_overflow)               overflow <= 1'b0;
    end
  end

  // NOTE: the storage array is deliberately not reset; the pointers and count
  // define which entries are meaningful, and an unreset array maps to plain RAM.
  always_ff @(negedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign count = 5'(count_q);

endmodule

// File: rtl/keypad_ctrl.sv
// keypad_ctrl: buffered 4x4 matrix-keypad controller on the MMIO bus.
//   clock  : system clock, all state changes on the falling edge
//   reset  : asynchronous, active-low
//   column : keypad columns (active-low, pulled up)
//   row    : keypad row drive (active-low)
//   bus    : keypad_ctrl_if.slave (read/write strobes, address, data, interrupt)
// Registers: DATA (pop-on-read), STATUS (read clears overflow), CTRL (irq_en, flush).
// Optional macro KEYPAD_AUTOREPEAT_EN: re-pushes a held key every REPEAT_CYCLES.
module keypad_ctrl
  import keypad_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'hFFFF,
  parameter int          FIFO_DEPTH      = 8,
  parameter logic [19:0] REPEAT_CYCLES   = 20'hFFFFF
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [3:0]   column,
  output logic [3:0]   row,
  keypad_ctrl_if.slave bus
);

  localparam logic [15:0] DEB_LAST = DEBOUNCE_CYCLES - 16'd1;

  scan_state_e state;
  logic [15:0] deb_cnt;
  logic [1:0]  scan_row;
  logic        scan_phase;   // 0: row settling, 1: column sampled
  logic        irq_en;
  logic        irq_q;

  logic        col_low;
  logic        scan_push;
  logic [3:0]  scan_code;
  logic        rpt_push;
  logic        push;
  logic [3:0]  push_data;

  logic        pop;
  logic        flush;
  logic        clear_ov;
  logic        ctrl_wr;
  logic        irq_en_next;
  logic        draining;

  logic [3:0]  head;
  logic        full;
  logic        empty;
  logic [4:0]  count;
  logic        overflow;

  assign col_low   = (column != 4'hF);
  assign scan_push = (state == SCAN) && scan_phase && col_low;
  assign scan_code = key_code(scan_row, lowest_zero(column));
  assign push      = scan_push | rpt_push;
  assign row       = (state == SCAN) ? ~(4'b0001 << scan_row) : 4'b0000;

  always_ff @(negedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      deb_cnt    <= '0;
      scan_row   <= '0;
      scan_phase <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          deb_cnt <= '0;
          if (col_low) state <= DEBOUNCE;
        end
        DEBOUNCE: begin
          if (!col_low) begin
            state   <= IDLE;
            deb_cnt <= '0;
          end else if (deb_cnt == DEB_LAST) begin
            state      <= SCAN;
            deb_cnt    <= '0;
            scan_row   <= 2'd0;
            scan_phase <= 1'b0;
          end else begin
            deb_cnt <= deb_cnt + 16'd1;
          end
        end
        SCAN: begin
          scan_phase <= ~scan_phase;
          if (scan_phase) begin
            if (col_low) begin
              state   <= RELEASE;
              deb_cnt <= '0;
            end else if (scan_row == 2'd3) begin
              state <= IDLE;  // glitch: key gone before any row matched
            end else begin
              scan_row <= scan_row + 2'd1;
            end
          end
        end
        RELEASE: begin
          if (col_low) begin
            deb_cnt <= '0;
          end else if (deb_cnt == DEB_LAST) begin
            state   <= IDLE;
            deb_cnt <= '0;
          end else begin
            deb_cnt <= deb_cnt + 16'd1;
          end
        end
      endcase
    end
  end

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam logic [19:0] RPT_LAST = REPEAT_CYCLES - 20'd1;

  logic [19:0] rpt_cnt;
  logic [3:0]  held_code;

  assign rpt_push  = (state == RELEASE) && col_low && (rpt_cnt == RPT_LAST);
  assign push_data = scan_push ? scan_code : held_code;

  always_ff @(negedge clock or negedge reset) begin
    if (!reset) begin
      rpt_cnt   <= '0;
      held_code <= '0;
    end else begin
      if (scan_push) held_code <= scan_code;
      if (state == RELEASE && col_low) rpt_cnt <= rpt_push ? 20'd0 : rpt_cnt + 20'd1;
      else                             rpt_cnt <= '0;
    end
  end
`else
  logic unused_repeat;
  assign unused_repeat = ^REPEAT_CYCLES;
  assign rpt_push      = 1'b0;
  assign push_data     = scan_code;
`endif

  // Bus decode
  assign ctrl_wr     = bus.write_enable && (bus.address == REG_CTRL);
  assign flush       = ctrl_wr && bus.write_data[CTRL_FLUSH];
  assign irq_en_next = ctrl_wr ? bus.write_data[CTRL_IRQ_EN] : irq_en;
  assign pop         = bus.read_enable && (bus.address == REG_DATA);
  assign clear_ov    = bus.read_enable && (bus.address == REG_STATUS);

  // The queue becomes empty at this edge: drop the interrupt on the same edge.
  assign draining = flush | (pop & (count == 5'd1) & ~push);

  logic unused_wdata;
  assign unused_wdata = ^bus.write_data[15:2];

  always_ff @(negedge clock or negedge reset) begin
    if (!reset) begin
      irq_en <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      irq_en <= irq_en_next;
      irq_q  <= irq_en_next & ~empty & ~draining;
    end
  end

  assign bus.interrupt = irq_q;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    bus.read_data_output = '0;
    case (bus.address)
      REG_DATA: begin
        bus.read_data_output[DATA_VALID] = ~empty;
        bus.read_data_output[3:0]        = empty ? 4'd0 : head;
      end
      REG_STATUS: begin
        bus.read_data_output[STAT_COUNT_LSB +: 5] = count;
        bus.read_data_output[STAT_OVERFLOW]       = overflow;
        bus.read_data_output[STAT_IRQ_EN]         = irq_en;
        bus.read_data_output[STAT_NONEMPTY]       = ~empty;
      end
      default: ;
    endcase
  end

  key_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clock          (clock),
    .reset          (reset),
    .push           (push),
    .push_data      (push_data),
    .pop            (pop),
    .flush          (flush),
    .clear_overflow (clear_ov),
    .head           (head),
    .full           (full),
    .empty          (empty),
    .count          (count),
    .overflow       (overflow)
  );

  logic unused_full;
  assign unused_full = full;

endmodule

// File: tb/tb_keypad_ctrl.sv
// tb_keypad_ctrl: directed self-checking bench for keypad_ctrl
// (DEBOUNCE_CYCLES=4, FIFO_DEPTH=8, REPEAT_CYCLES=10). The DUT acts on the
// falling edge, so the bench drives and samples around the rising edge.
// A small keypad model pulls the configured column mask low while the key is
// down and the key's row is driven low.
module tb_keypad_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] column;
  logic [3:0] row;

  logic       key_down;
  logic [1:0] key_row;
  logic [3:0] key_mask;

  int checks = 0;
  int errors = 0;

  keypad_ctrl_if bus ();

  keypad_ctrl #(
    .DEBOUNCE_CYCLES (16'd4),
    .FIFO_DEPTH      (8),
    .REPEAT_CYCLES   (20'd10)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .column (column),
    .row    (row),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  assign column = (key_down && (row[key_row] == 1'b0)) ? key_mask : 4'hF;

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  // One-cycle read strobe; data sampled just after the rising edge.
  task automatic read_check(input string tag, input logic [2:0] a, input logic [15:0] exp);
    logic [15:0] d;
    bus.address     = a;
    bus.read_enable = 1'b1;
    #1 d = bus.read_data_output;
    @(posedge clock);
    bus.read_enable = 1'b0;
    check(tag, d, exp);
  endtask

  task automatic write_reg(input logic [2:0] a, input logic [15:0] d);
    bus.address      = a;
    bus.write_data   = d;
    bus.write_enable = 1'b1;
    @(posedge clock);
    bus.write_enable = 1'b0;
  endtask

  task automatic press(input logic [1:0] r, input logic [3:0] m, input int hold, input int gap);
    key_row  = r;
    key_mask = m;
    key_down = 1'b1;
    tick(hold);
    key_down = 1'b0;
    tick(gap);
  endtask

  initial begin
    reset            = 1'b0;
    key_down         = 1'b0;
    key_row          = 2'd0;
    key_mask         = 4'hF;
    bus.read_enable  = 1'b0;
    bus.write_enable = 1'b0;
    bus.address      = 3'b000;
    bus.write_data   = 16'h0000;
    tick(3);
    reset = 1'b1;
    tick(2);

    // Reset state
    check("reset_row", {12'd0, row}, 16'h0000);
    check("reset_irq", {15'd0, bus.interrupt}, 16'h0000);
    read_check("reset_status", 3'b010, 16'h0000);
    read_check("reset_data", 3'b000, 16'h0000);
    read_check("reset_other", 3'b110, 16'h0000);

    // Single press row 1 / column 1101 -> '5'; push lands on the 9th edge
    write_reg(3'b100, 16'h0001);
    key_row  = 2'd1;
    key_mask = 4'b1101;
    key_down = 1'b1;
    tick(8);
    read_check("lat_before_push", 3'b010, 16'h0002);
    check("irq_at_push", {15'd0, bus.interrupt}, 16'h0000);
    read_check("lat_after_push", 3'b010, 16'h000B);
    check("irq_rises", {15'd0, bus.interrupt}, 16'h0001);
    tick(30);
    key_down = 1'b0;
    tick(12);
    check("irq_held", {15'd0, bus.interrupt}, 16'h0001);
    read_check("data_5", 3'b000, 16'h8005);
    check("irq_falls", {15'd0, bus.interrupt}, 16'h0000);
    read_check("data_empty", 3'b000, 16'h0000);
    read_check("status_empty", 3'b010, 16'h0002);

    // 3-cycle glitch: shorter than debounce, nothing pushed
    press(2'd0, 4'b1110, 3, 10);
    read_check("glitch_status", 3'b010, 16'h0002);
    check("glitch_irq", {15'd0, bus.interrupt}, 16'h0000);
    check("glitch_row", {12'd0, row}, 16'h0000);

    // Nine presses into an 8-deep queue (includes a multi-column press)
    press(2'd0, 4'b1110, 20, 10);  // 1
    press(2'd0, 4'b0111, 20, 10);  // A
    press(2'd2, 4'b1001, 20, 10);  // 8 (lowest low column wins)
    press(2'd3, 4'b1110, 20, 10);  // E
    press(2'd3, 4'b1011, 20, 10);  // F
    press(2'd3, 4'b0111, 20, 10);  // D
    press(2'd2, 4'b1011, 20, 10);  // 9
    press(2'd1, 4'b0111, 20, 10);  // B
    press(2'd3, 4'b1101, 20, 10);  // 0 -> dropped
    check("full_irq", {15'd0, bus.interrupt}, 16'h0001);
    read_check("full_status_ovf", 3'b010, 16'h0047);
    read_check("full_status_clr", 3'b010, 16'h0043);
    read_check("drain_0", 3'b000, 16'h8001);
    read_check("drain_1", 3'b000, 16'h800A);
    read_check("drain_2", 3'b000, 16'h8008);
    read_check("drain_3", 3'b000, 16'h800E);
    read_check("drain_4", 3'b000, 16'h800F);
    read_check("drain_5", 3'b000, 16'h800D);
    read_check("drain_6", 3'b000, 16'h8009);
    read_check("drain_7", 3'b000, 16'h800B);
    read_check("drain_empty", 3'b000, 16'h0000);

    // Pop in the same cycle as a push with count=3
    press(2'd0, 4'b1110, 20, 10);  // 1
    press(2'd0, 4'b1101, 20, 10);  // 2
    press(2'd0, 4'b1011, 20, 10);  // 3
    read_check("count3", 3'b010, 16'h001B);
    key_row  = 2'd1;
    key_mask = 4'b1110;            // 4, pushed on the 9th edge
    key_down = 1'b1;
    tick(8);
    read_check("pop_push_head", 3'b000, 16'h8001);
    read_check("pop_push_count", 3'b010, 16'h001B);
    tick(10);
    key_down = 1'b0;
    tick(10);
    read_check("pp_drain_0", 3'b000, 16'h8002);
    read_check("pp_drain_1", 3'b000, 16'h8003);
    read_check("pp_drain_2", 3'b000, 16'h8004);
    read_check("pp_drain_empty", 3'b000, 16'h0000);

    // Flush
    press(2'd2, 4'b1110, 20, 10);  // 7
    read_check("pre_flush", 3'b010, 16'h000B);
    write_reg(3'b100, 16'h0003);
    read_check("post_flush", 3'b010, 16'h0002);
    check("flush_irq", {15'd0, bus.interrupt}, 16'h0000);

    // Reset mid-operation
    press(2'd1, 4'b1011, 20, 10);  // 6
    key_row  = 2'd1;
    key_mask = 4'b1011;
    key_down = 1'b1;
    tick(15);
    reset = 1'b0;
    tick(2);
    check("midrst_row", {12'd0, row}, 16'h0000);
    check("midrst_irq", {15'd0, bus.interrupt}, 16'h0000);
    read_check("midrst_status", 3'b010, 16'h0000);
    key_down = 1'b0;
    tick(2);
    reset = 1'b1;
    tick(3);
    read_check("after_rst_status", 3'b010, 16'h0000);
    read_check("after_rst_data", 3'b000, 16'h0000);

`ifdef KEYPAD_AUTOREPEAT_EN
    // Key 0 held 35 cycles past the first push: pushes at +0, +10, +20, +30
    press(2'd3, 4'b1101, 48, 10);
    read_check("rpt_status", 3'b010, 16'h0021);
    read_check("rpt_0", 3'b000, 16'h8000);
    read_check("rpt_1", 3'b000, 16'h8000);
    read_check("rpt_2", 3'b000, 16'h8000);
    read_check("rpt_3", 3'b000, 16'h8000);
    read_check("rpt_empty", 3'b000, 16'h0000);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
